// File: rtl/bus_arbiter.sv
// bus_arbiter
// Round-robin arbiter for the shared 8-bit data bus. N register-transfer
// sources (PC, ALU, MDR, ...) request the bus. One owner at a time receives
// a one-hot grant. bus_en drives the gated latch enables of the destination
// registers. A single dead turnaround cycle always separates two owners, so
// no latch is enabled while bus ownership changes hands.
//
// Handshake: req[i] is a level request. A requester owns the bus for every
// cycle in which grant[i] is high. It keeps req[i] high for as long as it
// wants the bus and drops it to give the bus up. The arbiter takes the bus
// back after MAX_HOLD cycles, but only when another requester is waiting.
//
// Ports:
//   clk       in   system clock; all state updates happen on the rising edge
//   reset     in   asynchronous, active-high reset
//   req       in   [N-1:0]   request vector
//   grant     out  [N-1:0]   registered one-hot grant; zero when there is no owner
//   grant_id  out  [IDW-1:0] index of the current or most recent owner
//   bus_en    out  high exactly when grant is non-zero
//   busy      out  high in the GRANT and TURN states
module bus_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = $clog2(N),
  parameter int CW       = $clog2(MAX_HOLD + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           bus_en,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t         state;
  logic [CW-1:0]  hold_cnt;
  logic [IDW-1:0] last;

  // Pick the first requester after 'l', scanning upward and wrapping modulo N.
  function automatic logic [IDW-1:0] pick(input logic [N-1:0] r,
                                          input logic [IDW-1:0] l);
    logic [IDW-1:0] w;
    logic [IDW-1:0] sel;
    logic           found;
    int             idx;
    w     = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(l) + k) % N;
      sel = IDW'(idx);
      if (!found && r[sel]) begin
        w     = sel;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  logic [IDW-1:0] winner;
  logic           owner_req;
  logic           others_req;
  logic           hold_full;
  logic           release_bus;

  always_comb begin
    winner      = pick(req, last);
    // grant holds the owner's one-hot code while in GRANT, so it doubles as a mask.
    owner_req   = |(req & grant);
    others_req  = |(req & ~grant);
    hold_full   = (hold_cnt == CW'(MAX_HOLD));
    release_bus = !owner_req || (hold_full && others_req);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      bus_en   <= 1'b0;
      busy     <= 1'b0;
      hold_cnt <= '0;
      last     <= IDW'(N - 1);
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state    <= GRANT;
            grant    <= {{(N-1){1'b0}}, 1'b1} << winner;
            grant_id <= winner;
            bus_en   <= 1'b1;
            busy     <= 1'b1;
            hold_cnt <= CW'(1);
          end
        end
        GRANT: begin
          if (release_bus) begin
            state  <= TURN;
            grant  <= '0;
            bus_en <= 1'b0;
            busy   <= 1'b1;
            last   <= grant_id;
          end else if (!hold_full) begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end
        TURN: begin
          if (|req) begin
            state    <= GRANT;
            grant    <= {{(N-1){1'b0}}, 1'b1} << winner;
            grant_id <= winner;
            bus_en   <= 1'b1;
            busy     <= 1'b1;
            hold_cnt <= CW'(1);
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          // Unreachable encoding: park in IDLE with every output cleared.
          state    <= IDLE;
          grant    <= '0;
          grant_id <= '0;
          bus_en   <= 1'b0;
          busy     <= 1'b0;
          hold_cnt <= '0;
        end
      endcase
    end
  end

  // Structural invariants
  a_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(grant));
  a_bus_en: assert property (@(posedge clk) disable iff (reset)
    bus_en == (|grant));
  a_busy_idle: assert property (@(posedge clk) disable iff (reset)
    !busy |-> (state == IDLE));
  a_no_handover: assert property (@(posedge clk) disable iff (reset)
    ((|$past(grant)) && (|grant)) |-> (grant == $past(grant)));

endmodule
